pwm_out: RTL and testbench

PWM_OUT -- requirements
Module: pwm_out

---
 rtl/pwm_out.sv | 111 +++++++++++
 tb/tb_pwm_out.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_out.sv
// Three-state PWM generator: 512-cycle frames, leading dead time, per-frame duty
// capture with volume shift, sticky fault on an illegal input pair.
module pwm_out #(
  parameter int unsigned DEADTIME = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [8:0] pos_in,
  input  logic [8:0] neg_in,
  input  logic [2:0] vol,
  output logic       frame_strobe,
  output logic       pwm_p,
  output logic       pwm_n,
  output logic       fault
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [9:0] DT = 10'(DEADTIME);

  state_t     state, state_nxt;
  logic [8:0] cnt, cnt_nxt;
  logic [8:0] duty_p, duty_p_nxt;
  logic [8:0] duty_n, duty_n_nxt;
  logic       fault_nxt;
  logic       pwm_p_nxt, pwm_n_nxt;
  logic       frame_end;
  logic       illegal;

  assign frame_end    = (cnt == 9'd511);
  assign illegal      = (pos_in != 9'd0) && (neg_in != 9'd0);
  assign frame_strobe = (state == RUN) && (cnt == 9'd0);

  // Position inside the high window that follows the dead time.
  function automatic logic in_window(input logic [8:0] c, input logic [8:0] duty);
    logic [9:0] cw;
    cw = {1'b0, c};
    return (cw >= DT) && ((cw - DT) < {1'b0, duty});
  endfunction

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    duty_p_nxt = duty_p;
    duty_n_nxt = duty_n;
    fault_nxt  = fault;

    case (state)
      IDLE: begin
        cnt_nxt = 9'd0;
        if (enable) state_nxt = RUN;
      end
      RUN: begin
        cnt_nxt = cnt + 9'd1;
        if (!enable) state_nxt = frame_end ? IDLE : DRAIN;
      end
      DRAIN: begin
        cnt_nxt = cnt + 9'd1;
        if (enable)         state_nxt = RUN;
        else if (frame_end) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 9'd0;
      end
    endcase

    if ((state != IDLE) && frame_end) begin
      if (illegal) begin
        duty_p_nxt = 9'd0;
        duty_n_nxt = 9'd0;
        fault_nxt  = 1'b1;
      end else begin
        duty_p_nxt = pos_in >> vol;
        duty_n_nxt = neg_in >> vol;
      end
    end

    // Leaving a frame for IDLE discards the captured duty so a restart begins dark.
    if (state_nxt == IDLE) begin
      cnt_nxt    = 9'd0;
      duty_p_nxt = 9'd0;
      duty_n_nxt = 9'd0;
    end

    pwm_p_nxt = (state_nxt != IDLE) && in_window(cnt_nxt, duty_p_nxt);
    pwm_n_nxt = (state_nxt != IDLE) && in_window(cnt_nxt, duty_n_nxt) && !pwm_p_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= 9'd0;
      duty_p <= 9'd0;
      duty_n <= 9'd0;
      fault  <= 1'b0;
      pwm_p  <= 1'b0;
      pwm_n  <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      duty_p <= duty_p_nxt;
      duty_n <= duty_n_nxt;
      fault  <= fault_nxt;
      pwm_p  <= pwm_p_nxt;
      pwm_n  <= pwm_n_nxt;
    end
  end

endmodule

// File: tb/tb_pwm_out.sv
// Bench for pwm_out: frame-level vector table, hand sequences for start-up, drain and
// mid-pulse reset, plus random stimulus against a frame-position reference model.
module tb_pwm_out;

  localparam int DT = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [8:0] pos_in, neg_in;
  logic [2:0] vol;
  logic       frame_strobe, pwm_p, pwm_n, fault;

  pwm_out #(.DEADTIME(DT)) dut (
    .clk(clk), .reset(reset), .enable(enable), .pos_in(pos_in), .neg_in(neg_in),
    .vol(vol), .frame_strobe(frame_strobe), .pwm_p(pwm_p), .pwm_n(pwm_n), .fault(fault)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_cycle_prints = 0;

  // Reference model: mode 0 idle, 1 running, 2 draining; position within the frame.
  int m_mode = 0, m_pos = 0, m_dp = 0, m_dn = 0;
  bit m_fault = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_edge();
    bit last;
    if (!reset) begin
      m_mode = 0; m_pos = 0; m_dp = 0; m_dn = 0; m_fault = 0;
    end else if (m_mode == 0) begin
      if (enable) begin m_mode = 1; m_pos = 0; end
    end else begin
      last = (m_pos == 511);
      if (last) begin
        if (pos_in != 0 && neg_in != 0) begin
          m_dp = 0; m_dn = 0; m_fault = 1;
        end else begin
          m_dp = int'(pos_in) / (1 << vol);
          m_dn = int'(neg_in) / (1 << vol);
        end
      end
      m_pos = (m_pos + 1) % 512;
      if (enable)     m_mode = 1;
      else if (last) begin m_mode = 0; m_pos = 0; m_dp = 0; m_dn = 0; end
      else            m_mode = 2;
    end
  endtask

  task automatic check_cycle();
    bit e_s, e_p, e_n;
    e_s = (m_mode == 1) && (m_pos == 0);
    e_p = (m_mode != 0) && (m_pos >= DT) && (m_pos - DT < m_dp);
    e_n = (m_mode != 0) && (m_pos >= DT) && (m_pos - DT < m_dn);
    n_tests++;
    if ({frame_strobe, pwm_p, pwm_n, fault} != {e_s, e_p, e_n, m_fault} || (pwm_p && pwm_n)) begin
      n_fail++;
      if (n_cycle_prints < 10) begin
        n_cycle_prints++;
        $display("FAIL cycle_model t=%0t pos=%0d: got strobe/p/n/fault=%b%b%b%b, expected %b%b%b%b",
                 $time, m_pos, frame_strobe, pwm_p, pwm_n, fault, e_s, e_p, e_n, m_fault);
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_cycle();
  endtask

  task automatic wait_strobe(input string name, output int steps);
    steps = 0;
    for (int i = 0; i < 1100; i++) begin
      step();
      steps++;
      if (frame_strobe) return;
    end
    check({name, "_timeout"}, 0, 1);
  endtask

  // Called while sampling a frame's first cycle; leaves the bench at the next one.
  task automatic measure_frame(output int hp, output int fp, output int lp,
                               output int hn, output int fn, output int ln);
    hp = 0; fp = -1; lp = -1; hn = 0; fn = -1; ln = -1;
    for (int k = 0; k < 512; k++) begin
      if (pwm_p) begin hp++; if (fp < 0) fp = k; lp = k; end
      if (pwm_n) begin hn++; if (fn < 0) fn = k; ln = k; end
      step();
    end
  endtask

  typedef struct {
    logic [8:0] pos, neg;
    logic [2:0] vol;
    int hp, fp, lp, hn, fn, ln;
    bit flt;
  } vec_t;

  vec_t vecs[7];
  int hp, fp, lp, hn, fn, ln, steps, strobes;

  initial begin
    vecs[0] = '{9'd100, 9'd0,   3'd0, 100, 4, 103,   0, -1, -1,  1'b0};
    vecs[1] = '{9'd0,   9'd511, 3'd2,   0, -1, -1, 127,  4, 130, 1'b0};
    vecs[2] = '{9'd0,   9'd511, 3'd0,   0, -1, -1, 508,  4, 511, 1'b0};
    vecs[3] = '{9'd12,  9'd25,  3'd0,   0, -1, -1,   0, -1, -1,  1'b1};
    vecs[4] = '{9'd0,   9'd0,   3'd0,   0, -1, -1,   0, -1, -1,  1'b1};
    vecs[5] = '{9'd7,   9'd0,   3'd3,   0, -1, -1,   0, -1, -1,  1'b1};
    vecs[6] = '{9'd511, 9'd0,   3'd1, 255, 4, 258,   0, -1, -1,  1'b1};

    reset = 1'b0; enable = 1'b1; pos_in = '0; neg_in = '0; vol = '0;
    for (int i = 0; i < 3; i++) step();
    check("reset_outputs", {frame_strobe, pwm_p, pwm_n, fault}, 0);

    // Start-up: first edge after release is a strobe, then every 512 cycles.
    reset = 1'b1;
    step();
    check("first_strobe", frame_strobe, 1);
    hp = 0;
    for (int f = 0; f < 2; f++) begin
      steps = 0;
      for (int i = 0; i < 1100; i++) begin
        step();
        steps++;
        if (pwm_p || pwm_n) hp++;
        if (frame_strobe) break;
      end
      check("strobe_spacing", steps, 512);
    end
    check("startup_outputs_low", hp, 0);

    foreach (vecs[i]) begin
      pos_in = vecs[i].pos; neg_in = vecs[i].neg; vol = vecs[i].vol;
      wait_strobe("vec_capture", steps);
      check("vec_fault_next_cycle", fault, int'(vecs[i].flt));
      measure_frame(hp, fp, lp, hn, fn, ln);
      check("vec_p_high", hp, vecs[i].hp);
      check("vec_p_first", fp, vecs[i].fp);
      check("vec_p_last", lp, vecs[i].lp);
      check("vec_n_high", hn, vecs[i].hn);
      check("vec_n_first", fn, vecs[i].fn);
      check("vec_n_last", ln, vecs[i].ln);
      check("vec_fault", fault, int'(vecs[i].flt));
    end

    // Drain: enable drops mid-frame, the frame still completes its 300-cycle pulse.
    pos_in = 9'd300; neg_in = '0; vol = '0;
    wait_strobe("drain_capture", steps);
    hp = 0;
    for (int k = 0; k < 512; k++) begin
      if (pwm_p) hp++;
      if (k == 200) enable = 1'b0;
      step();
    end
    check("drain_high", hp, 300);
    check("drain_no_strobe_at_end", frame_strobe, 0);
    strobes = 0; hp = 0;
    for (int i = 0; i < 600; i++) begin
      step();
      if (frame_strobe) strobes++;
      if (pwm_p || pwm_n) hp++;
    end
    check("idle_strobes", strobes, 0);
    check("idle_outputs", hp, 0);
    enable = 1'b1;
    wait_strobe("restart", steps);
    check("restart_latency", steps, 1);
    measure_frame(hp, fp, lp, hn, fn, ln);
    check("restart_first_frame_low", hp + hn, 0);
    measure_frame(hp, fp, lp, hn, fn, ln);
    check("restart_second_frame", hp, 300);

    // Random stimulus, compared every cycle against the model.
    for (int i = 0; i < 8000; i++) begin
      if ($urandom_range(0, 399) == 0) enable = ~enable;
      if ($urandom_range(0, 63) == 0) begin
        case ($urandom_range(0, 3))
          0: begin pos_in = 9'($urandom); neg_in = '0; end
          1: begin neg_in = 9'($urandom); pos_in = '0; end
          2: begin pos_in = 9'($urandom); neg_in = 9'($urandom); end
          default: begin pos_in = '0; neg_in = '0; end
        endcase
        vol = 3'($urandom);
      end
      step();
    end

    // Reset in the middle of a high pulse acts without a clock edge.
    enable = 1'b1; pos_in = 9'd100; neg_in = '0; vol = '0;
    wait_strobe("rst_seq_a", steps);
    wait_strobe("rst_seq_b", steps);
    for (int k = 0; k < 50; k++) step();
    check("pulse_before_reset", pwm_p, 1);
    #2 reset = 1'b0;
    #1;
    check("async_reset_pwm_p", pwm_p, 0);
    check("async_reset_cnt", int'(dut.cnt), 0);
    check("async_reset_fault", fault, 0);
    check("async_reset_strobe", frame_strobe, 0);
    step();
    reset = 1'b1;
    step();
    check("strobe_after_reset", frame_strobe, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
